// File: rtl/mem_access_unit.sv
// mem_access_unit -- MA-stage load/store front end sitting directly upstream
// of DATA_MEMORY.
//
// What it does:
//   - Decodes RV32 load/store funct3 into DATA_MEMORY size codes
//     (01 byte, 10 half, 11 word).
//   - Sign- or zero-extends the load data.
//   - Handles misaligned accesses, depending on the build:
//       MAU_MISALIGN_SPLIT_EN defined: a misaligned load becomes two aligned
//         word reads, and a misaligned store becomes one byte write per cycle.
//       Not defined: a misaligned access is blocked from DATA_MEMORY and
//         MISALIGN_FAULT pulses for that cycle.
//
// Handshake: there is no valid/ready pair. A request is level-held by the
// pipeline (mem_read_i / mem_write_i with funct3_i, addr_i and store_data_i
// kept stable). While busy_o=1 the pipeline must keep holding it. The
// request is complete in the cycle where busy_o=0. Dropping the request
// mid-sequence aborts the sequence at the next edge.
//
// Ports:
//   clk_i, rst_ni          clock (posedge), async active-low reset
//   mem_read_i/mem_write_i load / store request (store wins if both are set)
//   funct3_i               RV32 funct3
//   addr_i, store_data_i   byte address, store operand
//   dmem_rdata_i           DATA_MEMORY DATA_OUT (combinational read)
//   dmem_read_o/_write_o   DATA_MEMORY READ / WRITE size codes
//   dmem_addr_o/_wdata_o   DATA_MEMORY ADDR / DATA_IN
//   load_data_o/_valid_o   extended load result and its valid flag
//   busy_o                 stall request to the upstream pipeline
//   misalign_fault_o       one-cycle pulse on a misaligned access (non-split build)
//   dbg_state_o            current FSM state, for observation
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [1:0]      dmem_read_o,
    output logic [1:0]      dmem_write_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            load_valid_o,
    output logic            busy_o,
    output logic            misalign_fault_o,
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_HI = 3'd1,
        S_ST_B1 = 3'd2,
        S_ST_B2 = 3'd3,
        S_ST_B3 = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            is_load, is_store, f3_ok, access, misaligned;
    logic [1:0]      size_code, last_idx, st_idx;
    logic [XLEN-1:0] aligned_addr;
    logic            ld_direct, ld_merge, capture_lo;
    logic [2*XLEN-1:0] merged;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  return {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b010:  return raw;
            3'b100:  return {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, raw[15:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_mask(input logic [XLEN-1:0] d, input logic [1:0] sz);
        case (sz)
            2'b01:   return {{(XLEN-8){1'b0}}, d[7:0]};
            2'b10:   return {{(XLEN-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_byte(input logic [XLEN-1:0] d, input logic [1:0] idx);
        logic [XLEN-1:0] s;
        s = d >> {idx, 3'b000};
        return {{(XLEN-8){1'b0}}, s[7:0]};
    endfunction

    assign is_store     = mem_write_i;
    assign is_load      = mem_read_i & ~mem_write_i;
    // BU/HU (100/101) exist only for loads.
    assign f3_ok        = (funct3_i inside {3'b000, 3'b001, 3'b010}) |
                          (is_load & (funct3_i inside {3'b100, 3'b101}));
    assign access       = (is_load | is_store) & f3_ok;
    assign size_code    = (funct3_i[1:0] == 2'b00) ? 2'b01 :
                          (funct3_i[1:0] == 2'b01) ? 2'b10 :
                          (funct3_i[1:0] == 2'b10) ? 2'b11 : 2'b00;
    assign misaligned   = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                          ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    assign last_idx     = (funct3_i[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign aligned_addr = {addr_i[XLEN-1:2], 2'b00};
    assign dbg_state_o  = state_q;

    always_comb begin
        case (state_q)
            S_ST_B1: st_idx = 2'd1;
            S_ST_B2: st_idx = 2'd2;
            S_ST_B3: st_idx = 2'd3;
            default: st_idx = 2'd0;
        endcase
    end

    // Control path. It does not look at dmem_rdata_i, so the memory's
    // combinational read cannot form a loop back through the address outputs.
    always_comb begin
        state_d          = state_q;
        dmem_read_o      = 2'b00;
        dmem_write_o     = 2'b00;
        dmem_addr_o      = addr_i;
        dmem_wdata_o     = '0;
        load_valid_o     = 1'b0;
        busy_o           = 1'b0;
        misalign_fault_o = 1'b0;
        ld_direct        = 1'b0;
        ld_merge         = 1'b0;
        capture_lo       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    if (is_store) begin
                        dmem_write_o = size_code;
                        dmem_wdata_o = store_mask(store_data_i, size_code);
                    end else begin
                        dmem_read_o  = size_code;
                        load_valid_o = 1'b1;
                        ld_direct    = 1'b1;
                    end
                end else if (access) begin
`ifdef MAU_MISALIGN_SPLIT_EN
                    busy_o = 1'b1;
                    if (is_store) begin
                        dmem_write_o = 2'b01;
                        dmem_wdata_o = store_byte(store_data_i, 2'd0);
                        state_d      = S_ST_B1;
                    end else begin
                        dmem_read_o  = 2'b11;
                        dmem_addr_o  = aligned_addr;
                        capture_lo   = 1'b1;
                        state_d      = S_LD_HI;
                    end
`else
                    misalign_fault_o = 1'b1;
`endif
                end else if (is_load) begin
                    // Invalid funct3 load: no memory access, and the result
                    // is reported as zero.
                    load_valid_o = 1'b1;
                end
            end

            S_LD_HI: begin
                state_d = S_IDLE;
                if (is_load) begin
                    dmem_read_o  = 2'b11;
                    dmem_addr_o  = aligned_addr + XLEN'(4);
                    load_valid_o = 1'b1;
                    ld_merge     = 1'b1;
                end
            end

            S_ST_B1, S_ST_B2, S_ST_B3: begin
                if (is_store) begin
                    dmem_write_o = 2'b01;
                    dmem_addr_o  = addr_i + {{(XLEN-2){1'b0}}, st_idx};
                    dmem_wdata_o = store_byte(store_data_i, st_idx);
                    if (st_idx == last_idx) begin
                        state_d = S_IDLE;
                    end else begin
                        busy_o  = 1'b1;
                        state_d = state_e'(state_q + 3'd1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are forced to zero while reset is asserted, without
        // waiting for a clock edge.
        if (!rst_ni) begin
            dmem_read_o      = 2'b00;
            dmem_write_o     = 2'b00;
            dmem_addr_o      = '0;
            dmem_wdata_o     = '0;
            load_valid_o     = 1'b0;
            busy_o           = 1'b0;
            misalign_fault_o = 1'b0;
        end
    end

    // Data path. The high word arriving in LD_HI is concatenated above the
    // captured low word, then shifted right by the byte offset.
    assign merged = {dmem_rdata_i, lo_q} >> {addr_i[1:0], 3'b000};

    always_comb begin
        lo_d        = lo_q;
        load_data_o = '0;
        if (capture_lo) lo_d = dmem_rdata_i;
        if (ld_direct)     load_data_o = extend(dmem_rdata_i, funct3_i);
        else if (ld_merge) load_data_o = extend(merged[XLEN-1:0], funct3_i);
        if (!rst_ni) load_data_o = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

endmodule
